// File: rtl/bka16_share_arb.sv
// ---------------------------------------------------------------------------
// bka16_share_arb
//   Time-shares one 16-bit Brent-Kung adder between NREQ operand producers.
//   A round-robin arbiter grants one requester per cycle whenever the single
//   response register can take a new result: it is empty, or it is full and
//   being drained in the same cycle. The granted pair is added and the sum,
//   carry-out and requester index are captured one cycle later.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req_valid  per-requester operand pair available
//   req_ready  per-requester accept (at most one bit set, Mealy on req_valid)
//   req_a/b    packed operands, requester i at [16*i+15:16*i]
//   rsp_valid  response register holds a result
//   rsp_ready  consumer takes the response this cycle
//   rsp_sum    a+b modulo 2^16
//   rsp_cout   carry out of bit 15
//   rsp_id     index of the requester that produced the result
//   op_count   accepted operations, wraps modulo 2^16
// ---------------------------------------------------------------------------

// 16-bit Brent-Kung adder, no carry-in. Generate/propagate pairs are combined
// in place: an up-sweep builds prefixes at positions 1,3,7,15, then a
// down-sweep fills the remaining positions. Within one level every updated
// position reads a lower position that the level leaves untouched, so the
// in-place update order does not matter.
module bka16_nocin (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;

    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int d = 1; d < 16; d = d * 2) begin
            for (int i = 15; i >= 0; i--) begin
                if (((i + 1) % (2 * d)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - d]);
                    p[i] = p[i] & p[i - d];
                end
            end
        end
        for (int d = 4; d >= 1; d = d / 2) begin
            for (int i = 15; i >= 0; i--) begin
                if ((((i + 1) % (2 * d)) == d) && (i >= 3 * d - 1)) begin
                    g[i] = g[i] | (p[i] & g[i - d]);
                end
            end
        end
        // g[i] is now the carry out of bit i.
        sum  = (a ^ b) ^ {g[14:0], 1'b0};
        cout = g[15];
    end
endmodule

module bka16_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          op_count
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    rsp_state_t      state_reg, state_next;
    logic [IDW-1:0]  last_grant_reg;
    logic [15:0]     rsp_sum_reg;
    logic            rsp_cout_reg;
    logic [IDW-1:0]  rsp_id_reg;
    logic [15:0]     op_count_reg;

    logic [15:0]     a_arr [NREQ];
    logic [15:0]     b_arr [NREQ];
    logic [IDW-1:0]  grant_idx;
    logic            grant_found;
    logic            can_acc;
    logic            xfer;
    logic [15:0]     add_sum;
    logic            add_cout;

    // Unpack the flat operand buses into per-requester words.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[16*gi +: 16];
            assign b_arr[gi] = req_b[16*gi +: 16];
        end
    endgenerate

    // Round-robin search starting just above last_grant. Scanning from the
    // farthest candidate down to the nearest lets the nearest valid one win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = int'(last_grant_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    assign can_acc   = (state_reg == ST_EMPTY) || rsp_ready;
    assign xfer      = grant_found && can_acc && !rst;
    assign req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;

    bka16_nocin u_add (
        .a    (a_arr[grant_idx]),
        .b    (b_arr[grant_idx]),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Response occupancy: a new accept always leaves the register full,
    // even when the old result drains at the same edge.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (xfer) state_next = ST_FULL;
            ST_FULL: begin
                if (xfer)           state_next = ST_FULL;
                else if (rsp_ready) state_next = ST_EMPTY;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_EMPTY;
            last_grant_reg <= IDW'(NREQ - 1);
            rsp_sum_reg    <= '0;
            rsp_cout_reg   <= 1'b0;
            rsp_id_reg     <= '0;
            op_count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (xfer) begin
                rsp_sum_reg    <= add_sum;
                rsp_cout_reg   <= add_cout;
                rsp_id_reg     <= grant_idx;
                last_grant_reg <= grant_idx;
                op_count_reg   <= op_count_reg + 16'd1;
            end
        end
    end

    assign rsp_valid = (state_reg == ST_FULL);
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign rsp_id    = rsp_id_reg;
    assign op_count  = op_count_reg;
endmodule

// File: tb/tb_bka16_share_arb.sv
// ---------------------------------------------------------------------------
// tb_bka16_share_arb
//   Directed scenarios plus a randomized run, each checked against a
//   behavioural model: round-robin as a modular search, sum/carry from plain
//   integer addition, a full/empty flag for the response register.
// ---------------------------------------------------------------------------
module tb_bka16_share_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*16-1:0]  req_a = '0;
    logic [NREQ*16-1:0]  req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [15:0]         rsp_sum;
    logic                rsp_cout;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         op_count;

    bka16_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_last = NREQ - 1;
    bit m_full = 0;
    int m_sum  = 0;
    int m_cout = 0;
    int m_id   = 0;
    int m_cnt  = 0;
    bit verbose = 1;

    function automatic int exp_grant();
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        g = exp_grant();
        if (rst || g < 0 || (m_full && !rsp_ready)) return '0;
        return NREQ'(1) << g;
    endfunction

    // Advance one clock edge and update the model with what the edge does.
    task automatic step();
        int g;
        bit acc;
        int a;
        int b;
        g   = exp_grant();
        acc = !rst && (g >= 0) && (!m_full || rsp_ready);
        a   = 0;
        b   = 0;
        if (acc) begin
            a = int'(req_a[16*g +: 16]);
            b = int'(req_b[16*g +: 16]);
        end
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_sum = 0; m_cout = 0; m_id = 0; m_cnt = 0; m_last = NREQ - 1;
        end else if (acc) begin
            m_sum  = (a + b) % 65536;
            m_cout = (a + b) / 65536;
            m_id   = g;
            m_last = g;
            m_cnt  = (m_cnt + 1) % 65536;
            m_full = 1;
            if (verbose)
                $display("xfer req%0d a=%04h b=%04h -> sum=%04h cout=%0d count=%0d",
                         g, a, b, m_sum, m_cout, m_cnt);
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== '0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        step(); step();
        n_checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, op_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b sum=%h cout=%b id=%0d cnt=%h want all 0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id, op_count);
        end
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_single_op();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_a[15:0] = 16'hFFFF;
        req_b[15:0] = 16'h0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, op_count} !== {1'b1, 16'h0000, 1'b1, 2'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL single_rsp: valid=%b sum=%h cout=%b id=%0d cnt=%0d want 1/0000/1/0/1",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id, op_count);
        end
        rsp_ready = 1'b1;
        step();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_fairness();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'($urandom);
            req_b[16*i +: 16] = 16'($urandom);
        end
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++;
            if (req_ready !== (NREQ'(1) << order[k])) begin
                n_fail++; $display("FAIL fair_ready[%0d]: got %b want req%0d", k, req_ready, order[k]);
            end
            step();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(order[k]) || rsp_sum !== 16'(m_sum)) begin
                n_fail++;
                $display("FAIL fair_rsp[%0d]: valid=%b id=%0d sum=%h want 1/%0d/%h",
                         k, rsp_valid, rsp_id, rsp_sum, order[k], m_sum);
            end
        end
    endtask

    // Entered FULL with last grant = 1 and all requesters valid.
    task automatic test_backpressure();
        logic [34:0] snap;
        rsp_ready = 1'b0;
        snap = {rsp_sum, rsp_cout, rsp_id, op_count};
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (req_ready !== '0) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready);
            end
            step();
            n_checks++;
            if (rsp_valid !== 1'b1 || {rsp_sum, rsp_cout, rsp_id, op_count} !== snap ||
                op_count !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b fields=%h want 1/%h", k, rsp_valid,
                         {rsp_sum, rsp_cout, rsp_id, op_count}, snap);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL bp_release_ready: got %b want 0100", req_ready);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || op_count !== snap[15:0] + 16'd1) begin
            n_fail++;
            $display("FAIL bp_release_rsp: valid=%b id=%0d cnt=%0d want 1/2/%0d",
                     rsp_valid, rsp_id, op_count, snap[15:0] + 16'd1);
        end
    endtask

    task automatic test_skip_idle();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        req_a[16 +: 16] = 16'h0F0F; req_b[16 +: 16] = 16'hF0F1;
        step();
        req_valid = 4'b1010;
        req_a[48 +: 16] = 16'h1234; req_b[48 +: 16] = 16'h4321;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL skip_ready3: got %b want 1000", req_ready);
        end
        step();
        n_checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_id} !== {1'b1, 16'h5555, 1'b0, 2'd3}) begin
            n_fail++;
            $display("FAIL skip_rsp3: valid=%b sum=%h cout=%b id=%0d want 1/5555/0/3",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL skip_ready1: got %b want 0010", req_ready);
        end
        step();
        n_checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_id} !== {1'b1, 16'h0000, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL skip_rsp1: valid=%b sum=%h cout=%b id=%0d want 1/0000/1/1",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] acc;
        rsp_ready = 1'b0;
        req_valid = '0;
        for (int n = 0; n < 400; n++) begin
            #1;
            n_checks++;
            if (req_ready !== exp_ready() || rsp_valid !== m_full || op_count !== 16'(m_cnt) ||
                (m_full && {rsp_sum, rsp_cout, rsp_id} !== {16'(m_sum), 1'(m_cout), IDW'(m_id)})) begin
                n_fail++;
                $display("FAIL rand[%0d]: ready=%b/%b valid=%b/%b cnt=%0d/%0d sum=%h/%h cout=%b/%0d id=%0d/%0d",
                         n, req_ready, exp_ready(), rsp_valid, m_full, op_count, m_cnt,
                         rsp_sum, m_sum, rsp_cout, m_cout, rsp_id, m_id);
            end
            acc = exp_ready();
            step();
            // Requesters keep valid and operands until their own transfer.
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_a[16*i +: 16] = 16'($urandom);
                    req_b[16*i +: 16] = 16'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
        end
        rst = 1'b0;
    endtask

    task automatic test_counter_wrap();
        int guard;
        do_reset();
        verbose = 0;
        req_valid = 4'hF; rsp_ready = 1'b1;
        guard = 0;
        while (m_cnt != 65535 && guard < 70000) begin
            step();
            guard++;
        end
        verbose = 1;
        #1;
        n_checks++;
        if (op_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_pre: op_count=%h want ffff", op_count);
        end
        step();
        n_checks++;
        if (op_count !== 16'h0000 || rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_post: op_count=%h valid=%b want 0000/1", op_count, rsp_valid);
        end
    endtask

    task automatic test_reset_full();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== '0) begin
            n_fail++; $display("FAIL rstfull_ready: got %b want 0000", req_ready);
        end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || op_count !== 16'h0000) begin
            n_fail++; $display("FAIL rstfull_state: valid=%b cnt=%h want 0/0000", rsp_valid, op_count);
        end
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rstfull_grant: got %b want 0001", req_ready);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 16'(m_sum)) begin
            n_fail++;
            $display("FAIL rstfull_rsp: valid=%b id=%0d sum=%h want 1/0/%h", rsp_valid, rsp_id, rsp_sum, m_sum);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_skip_idle();
        test_random();
        test_counter_wrap();
        test_reset_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
